// File: rtl/segment_loader.sv
// ---------------------------------------------------------------------------
// segment_loader
//
// Parses CMD_PUSH_SEG (0x10) packets arriving as bytes from the SPI slave.
// Each packet's XOR checksum is checked, and good segments are buffered in a
// DEPTH-entry show-ahead FIFO. The FIFO head is presented to the step
// generator through a valid/ready handshake.
//
// Ports:
//   sys_clk, sys_rst_n    clock and asynchronous active-low reset
//   rx_data, rx_valid     received SPI byte and its one-cycle strobe
//   spi_cs_n              high aborts any packet in progress
//   flush                 one-cycle strobe: empties the FIFO and aborts the parser
//   clear_errors          clears crc_err_count and overflow
//   segment_valid/ready   handshake for the FIFO head
//   target_pos            head axis positions, with axis0 in the LSBs
//   entry/cruise/exit_velocity, acceleration   head motion fields
//   fifo_count/empty/full occupancy status
//   crc_err_count         saturating count of packets rejected for a bad checksum
//   overflow              sticky flag: a good packet was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module segment_loader #(
   parameter int NUM_AXES       = 3,
   parameter int STEP_WIDTH     = 32,
   parameter int VELOCITY_WIDTH = 24,
   parameter int DEPTH          = 32
) (
   input  logic                           sys_clk,
   input  logic                           sys_rst_n,
   input  logic [7:0]                     rx_data,
   input  logic                           rx_valid,
   input  logic                           spi_cs_n,
   input  logic                           flush,
   input  logic                           clear_errors,
   output logic                           segment_valid,
   input  logic                           segment_ready,
   output logic [NUM_AXES*STEP_WIDTH-1:0] target_pos,
   output logic [VELOCITY_WIDTH-1:0]      entry_velocity,
   output logic [VELOCITY_WIDTH-1:0]      cruise_velocity,
   output logic [VELOCITY_WIDTH-1:0]      exit_velocity,
   output logic [VELOCITY_WIDTH-1:0]      acceleration,
   output logic [$clog2(DEPTH):0]         fifo_count,
   output logic                           fifo_empty,
   output logic                           fifo_full,
   output logic [7:0]                     crc_err_count,
   output logic                           overflow
);

   localparam int PAYLOAD_BYTES = NUM_AXES*4 + 12;
   localparam int PAYLOAD_BITS  = PAYLOAD_BYTES*8;
   localparam int PTR_W         = $clog2(DEPTH);
   localparam int CNT_W         = PTR_W + 1;
   localparam int BCNT_W        = $clog2(PAYLOAD_BYTES);
   localparam logic [7:0] CMD_PUSH_SEG = 8'h10;

   typedef enum logic [1:0] {ST_IDLE, ST_PAYLOAD, ST_CHECK} state_t;

   state_t                  state_reg;
   logic [BCNT_W-1:0]       byte_cnt_reg;
   logic [7:0]              xor_reg;
   logic [PAYLOAD_BITS-1:0] asm_reg;
   logic [7:0]              crc_err_count_reg;
   logic                    overflow_reg;

   logic [PAYLOAD_BITS-1:0] mem [DEPTH];
   logic [PTR_W-1:0]        wr_ptr_reg;
   logic [PTR_W-1:0]        rd_ptr_reg;
   logic [CNT_W-1:0]        count_reg;

   logic                    chk_byte;
   logic                    pkt_good;
   logic                    pkt_bad;
   logic                    full_int;
   logic                    pop;
   logic                    push;
   logic                    drop;
   logic [PAYLOAD_BITS-1:0] head;

   // A checksum byte counts only when the packet has not been aborted by
   // chip-select or a flush in the same cycle.
   assign chk_byte = (state_reg == ST_CHECK) && rx_valid && !spi_cs_n && !flush;
   assign pkt_good = chk_byte && (rx_data == xor_reg);
   assign pkt_bad  = chk_byte && (rx_data != xor_reg);
   assign full_int = (count_reg == CNT_W'(DEPTH));
   assign pop      = (count_reg != '0) && segment_ready && !flush;
   // At full, a push is still accepted when a pop frees a slot on the same edge.
   assign push     = pkt_good && (!full_int || pop);
   assign drop     = pkt_good && full_int && !pop;

   // Parser FSM and error status.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg         <= ST_IDLE;
         byte_cnt_reg      <= '0;
         xor_reg           <= '0;
         asm_reg           <= '0;
         crc_err_count_reg <= '0;
         overflow_reg      <= 1'b0;
      end else begin
         if (flush || spi_cs_n) begin
            state_reg <= ST_IDLE;
         end else if (rx_valid) begin
            case (state_reg)
               ST_IDLE: begin
                  if (rx_data == CMD_PUSH_SEG) begin
                     state_reg    <= ST_PAYLOAD;
                     byte_cnt_reg <= '0;
                     xor_reg      <= '0;
                  end
               end
               ST_PAYLOAD: begin
                  // Bytes arrive MSB first, so after the last shift the first
                  // payload byte sits at the top of the assembly register.
                  asm_reg      <= {asm_reg[PAYLOAD_BITS-9:0], rx_data};
                  xor_reg      <= xor_reg ^ rx_data;
                  byte_cnt_reg <= byte_cnt_reg + BCNT_W'(1);
                  if (byte_cnt_reg == BCNT_W'(PAYLOAD_BYTES-1))
                     state_reg <= ST_CHECK;
               end
               ST_CHECK: state_reg <= ST_IDLE;
               default:  state_reg <= ST_IDLE;
            endcase
         end

         // A clear on the same cycle as an error event takes precedence.
         if (clear_errors) begin
            crc_err_count_reg <= '0;
            overflow_reg      <= 1'b0;
         end else begin
            if (pkt_bad && crc_err_count_reg != 8'hFF)
               crc_err_count_reg <= crc_err_count_reg + 8'd1;
            if (drop)
               overflow_reg <= 1'b1;
         end
      end
   end

   // FIFO pointers and occupancy. A flush overrides any push or pop.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage has no reset; contents are meaningless while the FIFO is empty.
   always_ff @(posedge sys_clk) begin
      if (push) mem[wr_ptr_reg] <= asm_reg;
   end

   // Show-ahead: the head entry is read combinationally.
   assign head = mem[rd_ptr_reg];

   for (genvar gi = 0; gi < NUM_AXES; gi++) begin : g_axis
      // axis0 was sent first, so it lies in the highest position field.
      assign target_pos[gi*STEP_WIDTH +: STEP_WIDTH] =
         STEP_WIDTH'(head[96 + (NUM_AXES-1-gi)*32 +: 32]);
   end

   assign entry_velocity  = VELOCITY_WIDTH'(head[72 +: 24]);
   assign cruise_velocity = VELOCITY_WIDTH'(head[48 +: 24]);
   assign exit_velocity   = VELOCITY_WIDTH'(head[24 +: 24]);
   assign acceleration    = VELOCITY_WIDTH'(head[0  +: 24]);

   assign fifo_count    = count_reg;
   assign fifo_empty    = (count_reg == '0);
   assign fifo_full     = full_int;
   assign segment_valid = (count_reg != '0);
   assign crc_err_count = crc_err_count_reg;
   assign overflow      = overflow_reg;

endmodule
